// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array job sequencer.
// sa_feed_cycles gives the length of the combined operand + zero-flush window.
package sa_pkg;

    localparam int SA_N      = 3;
    localparam int SA_KW     = 8;
    localparam int SA_RD_LAT = 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DRAIN,
        DONE
    } sa_seq_state_t;

    function automatic int sa_feed_cycles(input int k, input int n);
        return k + 2 * n - 2;
    endfunction

endpackage

// File: rtl/sa_seq_delay_line.sv
// DEPTH-stage 1-bit shift register aligning rd_en with operand-buffer data.
// DEPTH=0 is a combinational pass-through.
module sa_seq_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q_o = d_i;
        end else begin : g_sr
            logic [DEPTH-1:0] sr_q;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    sr_q <= '0;
                end else begin
                    sr_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        sr_q[i] <= sr_q[i-1];
                    end
                end
            end

            assign q_o = sr_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sa_job_sequencer.sv
// Sequences one matmul job: clear, K operand reads, skewed zero flush, row drain.
// Define SA_SEQ_PERF_EN to add the perf_cycles / perf_stalls counters.
module sa_job_sequencer
    import sa_pkg::*;
#(
    parameter int N      = SA_N,
    parameter int KW     = SA_KW,
    parameter int RD_LAT = SA_RD_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef SA_SEQ_PERF_EN
    output logic [31:0]          perf_cycles,
    output logic [31:0]          perf_stalls,
`endif
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [KW-1:0]        k_len,
    output logic                 busy,
    output logic                 acc_clr,
    output logic                 rd_en,
    output logic [KW-1:0]        rd_addr,
    output logic                 feed_en,
    output logic                 zero_inj,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_row,
    output logic                 done,
    output logic                 err
);

    localparam int FLN = RD_LAT + 2 * N - 2;
    localparam int FW  = $clog2(RD_LAT + 2 * N - 1);
    localparam int RW  = $clog2(N);

    sa_seq_state_t state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [KW-1:0] addr_q, addr_d;
    logic [FW-1:0] fl_q, fl_d;
    logic [RW-1:0] row_q, row_d;
    logic          err_q, err_d;
    logic          rd_dly;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            addr_q  <= '0;
            fl_q    <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            fl_q    <= fl_d;
            row_q   <= row_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        addr_d  = addr_q;
        fl_d    = fl_q;
        row_d   = row_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    if (k_len != '0) begin
                        k_d     = k_len;
                        state_d = CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                addr_d  = '0;
                state_d = FEED;
            end
            FEED: begin
                if (addr_q == k_q - 1'b1) begin
                    addr_d  = '0;
                    fl_d    = '0;
                    state_d = FLUSH;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            FLUSH: begin
                if (fl_q == FW'(FLN - 1)) begin
                    fl_d    = '0;
                    row_d   = '0;
                    state_d = DRAIN;
                end else begin
                    fl_d = fl_q + 1'b1;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (row_q == RW'(N - 1)) begin
                        row_d   = '0;
                        state_d = DONE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Zero injection covers the FLUSH tail once the delayed reads have drained.
    always_comb begin
        start_ready = 1'b0;
        busy        = 1'b1;
        acc_clr     = 1'b0;
        rd_en       = 1'b0;
        zero_inj    = 1'b0;
        out_valid   = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
            end
            CLEAR: acc_clr = 1'b1;
            FEED:  rd_en = 1'b1;
            FLUSH: zero_inj = ({1'b0, fl_q} + (FW+1)'(1)) > (FW+1)'(RD_LAT);
            DRAIN: out_valid = 1'b1;
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

    sa_seq_delay_line #(
        .DEPTH(RD_LAT)
    ) u_dly (
        .clk(clk),
        .rst(rst),
        .d_i(rd_en),
        .q_o(rd_dly)
    );

    assign feed_en = rd_dly | zero_inj;
    assign rd_addr = addr_q;
    assign out_row = row_q;
    assign err     = err_q;

`ifdef SA_SEQ_PERF_EN
    logic [31:0] pcyc_q, pstl_q;
    logic        accept;

    assign accept = (state_q == IDLE) && start_valid && (k_len != '0);

    // Accept cycle counts as the first cycle of the job.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pcyc_q <= '0;
            pstl_q <= '0;
        end else if (accept) begin
            pcyc_q <= 32'd1;
            pstl_q <= '0;
        end else if (busy) begin
            if (pcyc_q != '1) pcyc_q <= pcyc_q + 1'b1;
            if (state_q == DRAIN && !out_ready && pstl_q != '1)
                pstl_q <= pstl_q + 1'b1;
        end
    end

    assign perf_cycles = pcyc_q;
    assign perf_stalls = pstl_q;
`endif

endmodule

// File: tb/tb_sa_job_sequencer.sv
// Scoreboard bench for sa_job_sequencer: queued rd_addr / out_row expectations
// plus per-job timing of the clear, feed, flush, drain and done phases.
module tb_sa_job_sequencer;
    import sa_pkg::*;

    localparam int N  = SA_N;
    localparam int KW = SA_KW;
    localparam int RL = SA_RD_LAT;
    localparam int RW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_valid = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          out_ready = 1'b1;
    logic          start_ready, busy, acc_clr, rd_en, feed_en, zero_inj;
    logic          out_valid, done, err;
    logic [KW-1:0] rd_addr;
    logic [RW-1:0] out_row;
`ifdef SA_SEQ_PERF_EN
    logic [31:0]   perf_cycles, perf_stalls;
`endif

    sa_job_sequencer dut (
        .clk(clk),
        .rst(rst),
`ifdef SA_SEQ_PERF_EN
        .perf_cycles(perf_cycles),
        .perf_stalls(perf_stalls),
`endif
        .start_valid(start_valid),
        .start_ready(start_ready),
        .k_len(k_len),
        .busy(busy),
        .acc_clr(acc_clr),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .feed_en(feed_en),
        .zero_inj(zero_inj),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_row(out_row),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs = 0;
    int miss = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int addr_sb[$];
    int row_sb[$];
    int t0 = 0;
    int t_acc, acc_n, rd_n, t_rd0, fe_n, t_fe0, t_fe1;
    int zi_n, t_zi0, t_zi1, t_ov0, t_done;
    int err_n = 0;
    int acc_tot = 0;
    int jobs = 0;

    always @(negedge clk) begin : mon
        int rel;
        rel = cyc - t0;
        if (rst) begin
            if (acc_clr) begin
                acc_n++;
                acc_tot++;
                t_acc = rel;
            end
            if (rd_en) begin
                if (t_rd0 < 0) t_rd0 = rel;
                rd_n++;
                if (addr_sb.size() == 0) check("rd_extra", 1, 0);
                else check("rd_addr", rd_addr, addr_sb.pop_front());
            end
            if (feed_en) begin
                if (t_fe0 < 0) t_fe0 = rel;
                t_fe1 = rel;
                fe_n++;
            end
            if (zero_inj) begin
                if (t_zi0 < 0) t_zi0 = rel;
                t_zi1 = rel;
                zi_n++;
            end
            if (out_valid) begin
                if (t_ov0 < 0) t_ov0 = rel;
                if (row_sb.size() == 0) check("row_extra", 1, 0);
                else begin
                    check("out_row", out_row, row_sb[0]);
                    if (out_ready) void'(row_sb.pop_front());
                end
            end
            if (done) t_done = rel;
            if (err) err_n++;
        end
    end

    task automatic arm(input int k);
        t0 = cyc;
        t_acc = -1; acc_n = 0; rd_n = 0; t_rd0 = -1;
        fe_n = 0; t_fe0 = -1; t_fe1 = -1;
        zi_n = 0; t_zi0 = -1; t_zi1 = -1; t_ov0 = -1; t_done = -1;
        for (int i = 0; i < k; i++) addr_sb.push_back(i);
        for (int r = 0; r < N; r++) row_sb.push_back(r);
        jobs++;
    endtask

    task automatic run_job(input int k, input int srow, input int sn,
                           input int inj);
        int  stalled;
        bit  got;
        stalled = 0;
        got = 1'b0;
        @(posedge clk); #1;
        check("rdy_at_start", start_ready, 1);
        arm(k);
        start_valid = 1'b1;
        k_len = KW'(k);
        for (int i = 0; i < 1000 && !got; i++) begin
            @(posedge clk); #1;
            if (done) got = 1'b1;
            else begin
                start_valid = (cyc - t0 == inj);
                k_len = KW'(9);
                out_ready = !(out_valid && int'(out_row) == srow && stalled < sn);
                if (!out_ready) stalled++;
            end
        end
        start_valid = 1'b0;
        out_ready = 1'b1;
        if (!got) check("done_timeout", 0, 1);
        check("busy_in_done", busy, 1);
        check("rdy_in_done", start_ready, 0);
        @(negedge clk); #1;
        check("acc_at", t_acc, 1);
        check("acc_cnt", acc_n, 1);
        check("rd_first", t_rd0, 2);
        check("rd_cnt", rd_n, k);
        check("fe_first", t_fe0, 2 + RL);
        check("fe_cnt", fe_n, sa_feed_cycles(k, N));
        check("fe_contig", t_fe1 - t_fe0 + 1, fe_n);
        check("zi_first", t_zi0, k + 2 + RL);
        check("zi_cnt", zi_n, 2 * N - 2);
        check("zi_last", t_zi1, t_fe1);
        check("ov_first", t_ov0, k + RL + 2 * N);
        check("done_at", t_done, k + RL + 3 * N + sn);
        check("rows_left", row_sb.size(), 0);
        check("addr_left", addr_sb.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", start_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_outs", {acc_clr, rd_en, feed_en, zero_inj, out_valid, done, err}, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_row", out_row, 0);
        rst = 1'b1;

        run_job(6, -1, 0, -1);
        run_job(6, 1, 3, -1);

        begin
            int a;
            @(posedge clk); #1;
            a = acc_tot;
            start_valid = 1'b1;
            k_len = '0;
            @(posedge clk); #1;
            start_valid = 1'b0;
            check("err_pulse", err, 1);
            check("err_busy", busy, 0);
            check("err_ready", start_ready, 1);
            @(posedge clk); #1;
            check("err_once", err, 0);
            check("err_noclr", acc_tot, a);
        end

        run_job(6, -1, 0, 4);
        run_job(1, 0, 2, -1);
        run_job(4, 2, 1, -1);

        begin
            bit hit;
            hit = 1'b0;
            @(posedge clk); #1;
            arm(6);
            start_valid = 1'b1;
            k_len = KW'(6);
            for (int i = 0; i < 50 && !hit; i++) begin
                @(posedge clk); #1;
                start_valid = 1'b0;
                if (rd_en && rd_addr == KW'(3)) hit = 1'b1;
            end
            if (!hit) check("abort_reach", 0, 1);
            rst = 1'b0;
            @(posedge clk); #1;
            check("abort_rd", rd_en, 0);
            check("abort_fe", feed_en, 0);
            check("abort_ready", start_ready, 1);
            check("abort_busy", busy, 0);
            rst = 1'b1;
            addr_sb.delete();
            row_sb.delete();
        end

        run_job(3, -1, 0, -1);

`ifdef SA_SEQ_PERF_EN
        run_job(6, 1, 2, -1);
        @(posedge clk); #1;
        check("perf_cycles", perf_cycles, 19);
        check("perf_stalls", perf_stalls, 2);
        repeat (3) @(posedge clk);
        #1;
        check("perf_hold", perf_cycles, 19);
`endif

        check("err_total", err_n, 1);
        check("acc_total", acc_tot, jobs);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
